muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit that executes the RV32M operations alongside the single-cycle ALU in the Execute stage. It accepts one operation per Start pulse and computes it over multiple cycles. While working it holds Busy, which the hazard unit uses to stall IF/ID/EX. It signals completion with a one-cycle Done pulse and holds Result until the next accepted Start.

Parameters:
XLEN, 32, operand/result width in bits; must be >= 8.
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per iteration; must be one of 1, 2, 4 and must divide XLEN.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  asynchronous, active-high reset.
Start  input  1  request; accepted only in IDLE or DONE state.
Flush  input  1  abort current operation (branch mispredict or trap from a later stage).
MD_Op  input  3  operation, RV32M funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
Src_A  input  XLEN  rs1 operand (dividend / multiplicand).
Src_B  input  XLEN  rs2 operand (divisor / multiplier).
Busy  output  1  high while an operation is in flight.
Done  output  1  one-cycle pulse; Result valid.
Result  output  XLEN  result; held stable from Done until the next accepted Start.

Behaviour:
- Clock and reset: one clock CLK; reset RST is asynchronous and active-high.
- Reset values: state IDLE, Busy 0, Done 0, Result 0, all internal registers 0. Reset applies immediately, including mid-operation.
- States: IDLE, MUL, DIV, FIXUP, DONE.
- Start acceptance: Start is sampled only in IDLE or DONE; MD_Op, Src_A and Src_B are latched on the accepting edge. Start in MUL, DIV or FIXUP is ignored, with no queueing.
- Operand conditioning at accept:
  - Signed ops (MULH, DIV, REM): operands are converted to magnitudes and the result sign is recorded.
  - MULHSU: only Src_A is treated as signed.
  - MUL uses the unsigned path; the low word is sign-agnostic.
- Special cases at accept go straight to DONE. Latency is 1, so Done is asserted in the cycle after Start.
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> Src_A.
  - Signed overflow, Src_A = 1 followed by XLEN-1 zeros and Src_B = all ones: DIV -> Src_A; REM -> 0.
- MUL state: shift-add over a 2*XLEN accumulator, MUL_BITS_PER_CYCLE bits per cycle, XLEN/MUL_BITS_PER_CYCLE iterations, then FIXUP.
  - FIXUP applies two's-complement negation if the recorded sign is negative.
  - FIXUP then selects the low word (MUL) or high word (MULH/MULHSU/MULHU).
- DIV state: restoring radix-2 division, one quotient bit per cycle, XLEN iterations, then FIXUP.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
- Latency, Start to Done: MUL ops XLEN/MUL_BITS_PER_CYCLE + 1 cycles; DIV ops XLEN + 1 cycles; special cases 1 cycle. With defaults: MUL 33 cycles, DIV 33 cycles.
- Busy: high in MUL, DIV and FIXUP; low in IDLE and DONE.
- Done: high exactly one cycle, in DONE.
  - DONE -> IDLE if no Start.
  - DONE -> MUL/DIV/DONE on Start, so back-to-back operations are possible.
- Iteration counter: clog2(XLEN)+1 bits, loaded at accept and decremented per iteration. Terminal count moves to FIXUP; there is no wrap-around.
- Flush: from any state, next state is IDLE. Done is not asserted and Result keeps its previous value.
  - Flush and Start in the same cycle: Flush wins and the Start is dropped.
- Width rules: all sign handling is two's complement, with negation = invert + 1 on XLEN bits.

Decomposition:
- Shared package definitions:
  - md_op_t enum holding the 3-bit MD_Op encodings above.
  - md_state_t enum (IDLE, MUL, DIV, FIXUP, DONE).
  - Constant MD_OPCODE_FUNCT7 = 7'b0000001, used by the decoder.
- Sub-module div_step: combinational single restoring-division iteration, parametrised by XLEN.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- Multiplier step, sequencer and FIXUP stay inline.

Test Plan:
1. MUL, Src_A=7, Src_B=0xFFFFFFFD -> Result 0xFFFFFFEB; Done exactly 33 cycles after Start; Busy high for cycles 1..32.
2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. Repeat with MUL_BITS_PER_CYCLE=4: same results, Done at cycle 9.
3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; Done at cycle 33.
4. Special cases, each with Done in cycle 1 and Busy never high:
   - DIVU 5/0 -> 0xFFFFFFFF
   - REM 5/0 -> 5
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
   - REM 0x80000000/0xFFFFFFFF -> 0
5. Flush and ignored Start:
   - Start DIV, assert Flush at cycle 10 -> Busy low at cycle 11, no Done, Result unchanged.
   - Start with new operands at cycle 5 of a MUL is ignored; the original result is returned.
6. Reset and back-to-back:
   - Assert RST asynchronously mid-MUL -> Busy, Done and Result 0 before the next edge; IDLE after release.
   - Start issued in the Done cycle begins the next operation; its Done arrives 33 cycles later.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: operation codes,
// sequencer states and the decoder's funct7 match value.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } md_state_t;

  localparam logic [6:0] MD_OPCODE_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module muldiv_unit_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            quot_bit
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  always_comb begin
    trial    = {rem_in, dividend_bit};
    diff     = trial - {1'b0, divisor};
    quot_bit = (trial >= {1'b0, divisor});
    rem_out  = quot_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage: shift-add
// multiplier, restoring divider, sign fixup and a Start/Busy/Done handshake.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic            Flush,
  input  logic [2:0]      MD_Op,
  input  logic [XLEN-1:0] Src_A,
  input  logic [XLEN-1:0] Src_B,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int MB = MUL_BITS_PER_CYCLE;
  localparam int CW = $clog2(XLEN) + 1;
  // The first iteration runs on the accepting edge, so the counter holds
  // the number of iterations still to go after that.
  localparam logic [CW-1:0]   MUL_LOAD = CW'(XLEN / MB - 1);
  localparam logic [CW-1:0]   DIV_LOAD = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         state, next_state;
  md_op_t            op_q, op_in;
  logic              neg_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [CW-1:0]     cnt;

  logic              accept, is_div, is_rem, signed_div;
  logic              div_zero, overflow, special;
  logic [XLEN-1:0]   special_val;
  logic [XLEN-1:0]   cond_a, cond_b;
  logic              cond_neg;
  logic [XLEN-1:0]   ds_rem_in, ds_divisor, ds_rem_out;
  logic              ds_bit, ds_quot;
  logic [2*XLEN-1:0] mul_first, prod;
  logic [XLEN-1:0]   div_sel, fix_val;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  // Retire MB multiplier bits: add multiplicand * digit to the high word,
  // then shift the whole accumulator right by MB.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] a,
                                                 input logic [XLEN-1:0]   mcand);
    logic [XLEN+MB-1:0] sum;
    sum = {{MB{1'b0}}, a[2*XLEN-1:XLEN]}
        + ({{MB{1'b0}}, mcand} * {{XLEN{1'b0}}, a[MB-1:0]});
    return {sum, a[XLEN-1:MB]};
  endfunction

  always_comb begin
    op_in      = md_op_t'(MD_Op);
    is_div     = MD_Op[2];
    is_rem     = MD_Op[1];
    signed_div = (op_in == OP_DIV) || (op_in == OP_REM);
    cond_a     = Src_A;
    cond_b     = Src_B;
    cond_neg   = 1'b0;
    case (op_in)
      OP_MULH, OP_DIV: begin
        cond_a   = Src_A[XLEN-1] ? neg_x(Src_A) : Src_A;
        cond_b   = Src_B[XLEN-1] ? neg_x(Src_B) : Src_B;
        cond_neg = Src_A[XLEN-1] ^ Src_B[XLEN-1];
      end
      OP_REM: begin
        cond_a   = Src_A[XLEN-1] ? neg_x(Src_A) : Src_A;
        cond_b   = Src_B[XLEN-1] ? neg_x(Src_B) : Src_B;
        cond_neg = Src_A[XLEN-1];
      end
      OP_MULHSU: begin
        cond_a   = Src_A[XLEN-1] ? neg_x(Src_A) : Src_A;
        cond_neg = Src_A[XLEN-1];
      end
      default: ;
    endcase
    div_zero = is_div && (Src_B == '0);
    overflow = signed_div && (Src_A == MIN_NEG) && (Src_B == '1);
    special  = div_zero || overflow;
    if (div_zero) special_val = is_rem ? Src_A : '1;
    else          special_val = is_rem ? '0 : Src_A;
    accept = ((state == ST_IDLE) || (state == ST_DONE)) && Start && !Flush;
  end

  // The divider step is shared between the accepting edge and the DIV state.
  always_comb begin
    ds_rem_in  = accept ? '0 : acc[2*XLEN-1:XLEN];
    ds_bit     = accept ? cond_a[XLEN-1] : acc[XLEN-1];
    ds_divisor = accept ? cond_b : opnd;
    mul_first  = mul_step({{XLEN{1'b0}}, cond_b}, cond_a);
  end

  muldiv_unit_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in       (ds_rem_in),
    .dividend_bit (ds_bit),
    .divisor      (ds_divisor),
    .rem_out      (ds_rem_out),
    .quot_bit     (ds_quot)
  );

  always_comb begin
    prod    = neg_q ? (~acc + (2*XLEN)'(1)) : acc;
    div_sel = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (op_q[2])
      fix_val = neg_q ? neg_x(div_sel) : div_sel;
    else if (op_q == OP_MUL)
      fix_val = prod[XLEN-1:0];
    else
      fix_val = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (special)     next_state = ST_DONE;
          else if (is_div) next_state = ST_DIV;
          else             next_state = ST_MUL;
        end else if (state == ST_DONE) begin
          next_state = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: if (cnt == CNT_LAST) next_state = ST_FIXUP;
      ST_FIXUP:       next_state = ST_DONE;
      default:        next_state = ST_IDLE;
    endcase
    if (Flush) next_state = ST_IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q   <= OP_MUL;
      neg_q  <= 1'b0;
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      Result <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      neg_q <= cond_neg;
      cnt   <= is_div ? DIV_LOAD : MUL_LOAD;
      if (special) begin
        Result <= special_val;
      end else if (is_div) begin
        acc  <= {ds_rem_out, cond_a[XLEN-2:0], ds_quot};
        opnd <= cond_b;
      end else begin
        acc  <= mul_first;
        opnd <= cond_a;
      end
    end else if (state == ST_MUL) begin
      acc <= mul_step(acc, opnd);
      cnt <= cnt - CW'(1);
    end else if (state == ST_DIV) begin
      acc <= {ds_rem_out, acc[XLEN-2:0], ds_quot};
      cnt <= cnt - CW'(1);
    end else if ((state == ST_FIXUP) && !Flush) begin
      Result <= fix_val;
    end
  end

  assign Busy = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIXUP);
  assign Done = (state == ST_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: radix-2 and radix-16 multiply,
// divide, special cases, flush, ignored Start, async reset and back-to-back ops.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        CLK, RST, Start, start4, Flush;
  logic [2:0]  MD_Op;
  logic [31:0] Src_A, Src_B;
  logic        Busy, Done, busy4, done4;
  logic [31:0] Result, result4;
  int          checks, errors;

  muldiv_unit #(.XLEN(32), .MUL_BITS_PER_CYCLE(1)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Flush(Flush), .MD_Op(MD_Op),
    .Src_A(Src_A), .Src_B(Src_B), .Busy(Busy), .Done(Done), .Result(Result)
  );

  muldiv_unit #(.XLEN(32), .MUL_BITS_PER_CYCLE(4)) dut4 (
    .CLK(CLK), .RST(RST), .Start(start4), .Flush(Flush), .MD_Op(MD_Op),
    .Src_A(Src_A), .Src_B(Src_B), .Busy(busy4), .Done(done4), .Result(result4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Called #1 after an edge; issues Start for one edge and then counts cycles
  // to Done, noting whether Busy was high on every cycle before it.
  task automatic run_op(input bit use4, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output bit busy_ok);
    logic d, bz;
    MD_Op = op; Src_A = a; Src_B = b;
    if (use4) start4 = 1'b1; else Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0; start4 = 1'b0;
    lat = 1; busy_ok = 1'b1;
    d = 1'b0; bz = 1'b0;
    while (lat < 200) begin
      d  = use4 ? done4 : Done;
      bz = use4 ? busy4 : Busy;
      if (d) break;
      if (!bz) busy_ok = 1'b0;
      @(posedge CLK); #1;
      lat++;
    end
    if (d && bz) busy_ok = 1'b0;
    res = use4 ? result4 : Result;
  endtask

  task automatic test_reset;
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", Done); end
    checks++; if (Result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h want 00000000", Result); end
  endtask

  task automatic test_mul;
    int lat; logic [31:0] res; bit bok;
    run_op(1'b0, OP_MUL, 32'd7, 32'hFFFF_FFFD, lat, res, bok);
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("[TB] FAIL mul_result got %h want ffffffeb", res); end
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL mul_latency got %0d want 33", lat); end
    checks++; if (!bok) begin errors++; $display("[TB] FAIL mul_busy got bad want high in cycles 1..32"); end
    @(posedge CLK); #1;
    checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL mul_done_pulse got %b want 0", Done); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL mul_idle_busy got %b want 0", Busy); end
  endtask

  task automatic test_mulh;
    logic [2:0]  ops [3] = '{OP_MULH, OP_MULHU, OP_MULHSU};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int lat; logic [31:0] res; bit bok;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        run_op(r == 1, ops[i], as[i], bs[i], lat, res, bok);
        checks++; if (res !== exp[i]) begin errors++; $display("[TB] FAIL mulh_r%0d_result[%0d] got %h want %h", r, i, res, exp[i]); end
        checks++; if (lat !== (r == 1 ? 9 : 33)) begin errors++; $display("[TB] FAIL mulh_r%0d_latency[%0d] got %0d want %0d", r, i, lat, (r == 1 ? 9 : 33)); end
        checks++; if (!bok) begin errors++; $display("[TB] FAIL mulh_r%0d_busy[%0d] got bad want high until Done", r, i); end
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int lat; logic [31:0] res; bit bok;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, ops[i], as[i], bs[i], lat, res, bok);
      checks++; if (res !== exp[i]) begin errors++; $display("[TB] FAIL div_result[%0d] got %h want %h", i, res, exp[i]); end
      checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL div_latency[%0d] got %0d want 33", i, lat); end
      checks++; if (!bok) begin errors++; $display("[TB] FAIL div_busy[%0d] got bad want high until Done", i); end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_special;
    logic [2:0]  ops [4] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat; logic [31:0] res; bit bok;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, ops[i], as[i], bs[i], lat, res, bok);
      checks++; if (res !== exp[i]) begin errors++; $display("[TB] FAIL special_result[%0d] got %h want %h", i, res, exp[i]); end
      checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL special_latency[%0d] got %0d want 1", i, lat); end
      checks++; if (!bok) begin errors++; $display("[TB] FAIL special_busy[%0d] got high want never high", i); end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_flush;
    int lat; logic [31:0] res; bit bok, saw_done;
    run_op(1'b0, OP_DIVU, 32'd100, 32'd7, lat, res, bok);
    @(posedge CLK); #1;
    MD_Op = OP_DIV; Src_A = 32'd1000; Src_B = 32'd3; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (9) begin @(posedge CLK); #1; end
    Flush = 1'b1;
    @(posedge CLK); #1;
    Flush = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy got %b want 0", Busy); end
    saw_done = 1'b0;
    repeat (40) begin
      if (Done) saw_done = 1'b1;
      @(posedge CLK); #1;
    end
    checks++; if (saw_done) begin errors++; $display("[TB] FAIL flush_no_done got 1 want 0"); end
    checks++; if (Result !== 32'd14) begin errors++; $display("[TB] FAIL flush_result got %h want 0000000e", Result); end
    MD_Op = OP_DIVU; Src_A = 32'd9; Src_B = 32'd3; Start = 1'b1; Flush = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0; Flush = 1'b0;
    checks++; if ({Busy, Done} !== 2'b00) begin errors++; $display("[TB] FAIL flush_start_state got %b want 00", {Busy, Done}); end
    @(posedge CLK); #1;
    checks++; if (Result !== 32'd14) begin errors++; $display("[TB] FAIL flush_start_result got %h want 0000000e", Result); end
  endtask

  task automatic test_ignored_start;
    int lat;
    MD_Op = OP_MUL; Src_A = 32'd6; Src_B = 32'd7; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    lat = 1;
    repeat (4) begin @(posedge CLK); #1; lat++; end
    Src_A = 32'd100; Src_B = 32'd100; Start = 1'b1;
    @(posedge CLK); #1; lat++;
    Start = 1'b0;
    while (!Done && lat < 200) begin @(posedge CLK); #1; lat++; end
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL ignored_latency got %0d want 33", lat); end
    checks++; if (Result !== 32'd42) begin errors++; $display("[TB] FAIL ignored_result got %h want 0000002a", Result); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid;
    MD_Op = OP_MUL; Src_A = 32'd3; Src_B = 32'd5; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (9) begin @(posedge CLK); #1; end
    #2 RST = 1'b1;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_done got %b want 0", Done); end
    checks++; if (Result !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_result got %h want 00000000", Result); end
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if ({Busy, Done} !== 2'b00) begin errors++; $display("[TB] FAIL rst_release_state got %b want 00", {Busy, Done}); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] res; bit bok;
    run_op(1'b0, OP_DIVU, 32'd100, 32'd7, lat, res, bok);
    checks++; if (res !== 32'd14) begin errors++; $display("[TB] FAIL b2b_first_result got %h want 0000000e", res); end
    run_op(1'b0, OP_REMU, 32'd100, 32'd7, lat, res, bok);
    checks++; if (res !== 32'd2) begin errors++; $display("[TB] FAIL b2b_second_result got %h want 00000002", res); end
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL b2b_second_latency got %0d want 33", lat); end
    checks++; if (!bok) begin errors++; $display("[TB] FAIL b2b_second_busy got bad want high until Done"); end
  endtask

  initial begin
    checks = 0; errors = 0;
    RST = 1'b1; Start = 1'b0; start4 = 1'b0; Flush = 1'b0;
    MD_Op = 3'd0; Src_A = '0; Src_B = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    test_reset;
    test_mul;
    test_mulh;
    test_div;
    test_special;
    test_flush;
    test_ignored_start;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
